// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 key receiver.
//   frame_state_t : receive frame FSM states
//   PS2_EXT/BRK   : scan-code prefix bytes (extended, break)
//   key_event_t   : one queued key event {ext, code, is_release}
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // "release" is a reserved word, so the break flag is named is_release.
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic       is_release;
  } key_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo -- key event queue with valid/ready read side.
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   push, push_evt : write strobe and event to enqueue
//   evt_valid      : head is valid (queue not empty)
//   evt_ready      : consumer accepts the head this cycle
//   head_evt       : head event (all zeros when empty)
//   overflow       : sticky, set when a push is dropped on a full queue
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  key_event_t push_evt,
  output logic       evt_valid,
  input  logic       evt_ready,
  output key_event_t head_evt,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  key_event_t    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          overflow_reg;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Extra pointer bit tells full (MSBs differ) from empty (all bits equal).
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = !empty && evt_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_evt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !wr_en) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign evt_valid = !empty;
  assign head_evt  = empty ? key_event_t'('0) : mem[rd_ptr_reg[AW-1:0]];
  assign overflow  = overflow_reg;

endmodule

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo -- PS/2 keyboard receiver with scan-code decoding and an
// event queue.
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   ps2_clock, ps2_data   : raw asynchronous PS/2 lines
//   evt_valid, evt_ready  : read handshake of the event queue
//   evt_code, evt_release : head event {extended, scan byte} and break flag
//   overflow              : sticky, an event was dropped
//   err_count             : saturating count of bad / timed-out frames
// Optional feature: define PS2_REPEAT_FILTER_EN to suppress typematic
// repeats (a make equal to the last pushed make with no break between).
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [8:0] evt_code,
  output logic       evt_release,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_reg, dat_sync_reg;
  logic          filt_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_reg, bit_reg;

  frame_state_t  state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_reg, par_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [7:0]    err_count_reg;

  logic          ext_reg, brk_reg;
  logic          make_push, push;
  key_event_t    push_evt, head_evt;

  // Synchronisers and glitch filter. The filtered level flips only after
  // FILTER_LEN consecutive samples that disagree with it; the falling flip
  // raises a one-cycle strobe together with the data sampled at that moment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_reg <= 2'b11;
      dat_sync_reg <= 2'b11;
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
      bit_reg      <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], ps2_clock};
      dat_sync_reg <= {dat_sync_reg[0], ps2_data};
      fall_reg     <= 1'b0;
      if (clk_sync_reg[1] != filt_reg) begin
        if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
          filt_reg     <= clk_sync_reg[1];
          filt_cnt_reg <= '0;
          fall_reg     <= ~clk_sync_reg[1];
          bit_reg      <= dat_sync_reg[1];
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    tmo_next     = '0;
    done_next    = 1'b0;
    err_next     = 1'b0;

    if (state_reg != IDLE && !fall_reg) begin
      if (tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
        state_next = IDLE;
        err_next   = 1'b1;
      end else begin
        tmo_next = tmo_reg + 1'b1;
      end
    end

    if (fall_reg) begin
      case (state_reg)
        IDLE: begin
          if (!bit_reg) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
            par_next     = 1'b0;
          end
        end
        DATA: begin
          shift_next   = {bit_reg, shift_reg[7:1]};
          par_next     = par_reg ^ bit_reg;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          par_next   = par_reg ^ bit_reg;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          // par_reg is the XOR of data and parity: 1 means odd parity holds.
          if (bit_reg && par_reg) begin
            done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'd0;
      par_reg       <= 1'b0;
      tmo_reg       <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_count_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      tmo_reg     <= tmo_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      if (err_reg && err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  // Scan-code decoding. done_reg is high the cycle after the stop-bit
  // sample; shift_reg still holds the byte since no new edge can follow
  // that quickly.
  assign make_push = done_reg && (shift_reg != PS2_EXT) && (shift_reg != PS2_BRK);

  always_comb begin
    push_evt            = '0;
    push_evt.ext        = ext_reg;
    push_evt.code       = shift_reg;
    push_evt.is_release = brk_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end else if (done_reg) begin
      if (shift_reg == PS2_EXT) begin
        ext_reg <= 1'b1;
      end else if (shift_reg == PS2_BRK) begin
        brk_reg <= 1'b1;
      end else begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       last_valid_reg;
  logic [8:0] last_code_reg;
  logic       repeat_hit;

  // A suppressed repeat never reaches the queue, so it cannot overflow it.
  assign repeat_hit = !brk_reg && last_valid_reg &&
                      (last_code_reg == {ext_reg, shift_reg});
  assign push = make_push && !repeat_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_valid_reg <= 1'b0;
      last_code_reg  <= 9'd0;
    end else if (make_push) begin
      if (brk_reg) begin
        last_valid_reg <= 1'b0;
      end else begin
        last_valid_reg <= 1'b1;
        last_code_reg  <= {ext_reg, shift_reg};
      end
    end
  end
`else
  assign push = make_push;
`endif

  ps2_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_evt (push_evt),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .head_evt (head_evt),
    .overflow (overflow)
  );

  assign evt_code    = {head_evt.ext, head_evt.code};
  assign evt_release = head_evt.is_release;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb_ps2_key_fifo -- self-checking bench for ps2_key_fifo. A small model of
// the prefix decoder pushes expected {release, code} values into a queue as
// frames are sent; a monitor pops and compares on every accepted event.
// Honours PS2_REPEAT_FILTER_EN in its model when defined.
module tb_ps2_key_fifo;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int FIFO_DEPTH  = 8;
  localparam int HALF        = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [8:0] evt_code;
  logic       evt_release;
  logic       overflow;
  logic [7:0] err_count;

  int assertions = 0;
  int failures   = 0;
  int ev_seen    = 0;
  int exp_err    = 0;

  logic [9:0] exp_q[$];
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic       m_last_v = 1'b0;
  logic [8:0] m_last = 9'd0;

  ps2_key_fifo #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_release(evt_release),
    .overflow   (overflow),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: samples on the falling edge, away from the pop edge.
  always @(negedge clock) begin
    if (!reset && evt_valid && evt_ready) begin
      logic [9:0] exp_v;
      ev_seen++;
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got rel=%0b code=%h, none required",
                 evt_release, evt_code);
      end else begin
        exp_v = exp_q.pop_front();
        if ({evt_release, evt_code} !== exp_v) begin
          failures++;
          $display("FAIL event got rel=%0b code=%h, required rel=%0b code=%h",
                   evt_release, evt_code, exp_v[9], exp_v[8:0]);
        end else begin
          $display("event rel=%0b code=%h ok", evt_release, evt_code);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clock = 1'b0;
    wait_cyc(HALF);
    ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(40);
  endtask

  // Model of prefix handling (and repeat filter when enabled).
  task automatic model_byte(input logic [7:0] b, input logic drop);
    logic suppress;
    suppress = 1'b0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
`ifdef PS2_REPEAT_FILTER_EN
      if (!m_brk && m_last_v && m_last == {m_ext, b}) suppress = 1'b1;
      else if (m_brk) m_last_v = 1'b0;
      else begin
        m_last_v = 1'b1;
        m_last   = {m_ext, b};
      end
`endif
      if (!suppress && !drop) exp_q.push_back({m_brk, m_ext, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_key(input logic [7:0] b, input logic drop);
    model_byte(b, drop);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_last_v = 1'b0;
    exp_err = 0;
    wait_cyc(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(4);
    assertions += 5;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b required 0", evt_valid); end
    if (evt_code !== 9'd0) begin failures++; $display("FAIL reset_code got %h required 000", evt_code); end
    if (evt_release !== 1'b0) begin failures++; $display("FAIL reset_release got %b required 0", evt_release); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b required 0", overflow); end
    if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err got %0d required 0", err_count); end
    $display("test_reset done");
    reset = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_single_make();
    int base;
    base = ev_seen;
    evt_ready = 1'b1;
    send_key(8'h1C, 1'b0);
    assertions += 2;
    if (ev_seen - base !== 1) begin failures++; $display("FAIL single_count got %0d required 1", ev_seen - base); end
    if (err_count !== 8'd0) begin failures++; $display("FAIL single_err got %0d required 0", err_count); end
    $display("test_single_make done");
  endtask

  task automatic test_ext_break();
    int base;
    base = ev_seen;
    send_key(8'hE0, 1'b0);
    send_key(8'hF0, 1'b0);
    assertions++;
    if (ev_seen != base) begin failures++; $display("FAIL prefix_no_event got %0d required 0", ev_seen - base); end
    send_key(8'h75, 1'b0);
    assertions++;
    if (ev_seen - base !== 1) begin failures++; $display("FAIL ext_break_count got %0d required 1", ev_seen - base); end
    $display("test_ext_break done");
  endtask

  task automatic test_errors();
    int base;
    base = ev_seen;
    send_frame(8'h1D, 1'b1, 1'b0);
    exp_err++;
    send_frame(8'h22, 1'b0, 1'b1);
    exp_err++;
    assertions += 2;
    if (err_count !== 8'(exp_err)) begin failures++; $display("FAIL frame_err got %0d required %0d", err_count, exp_err); end
    if (ev_seen != base) begin failures++; $display("FAIL frame_err_events got %0d required 0", ev_seen - base); end
    $display("test_errors done");
  endtask

  task automatic test_timeout();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT_CYC + 200);
    exp_err++;
    assertions++;
    if (err_count !== 8'(exp_err)) begin failures++; $display("FAIL timeout_err got %0d required %0d", err_count, exp_err); end
    send_key(8'h2B, 1'b0);
    $display("test_timeout done");
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_key(8'(8'h15 + i), (i == 8));
    assertions += 3;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_flag got %b required 1", overflow); end
    if (evt_valid !== 1'b1) begin failures++; $display("FAIL overflow_valid got %b required 1", evt_valid); end
    if ({evt_release, evt_code} !== 10'h015) begin failures++; $display("FAIL overflow_head got %h required 015", evt_code); end
    evt_ready = 1'b1;
    wait_cyc(30);
    assertions += 2;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_left got %0d required 0", exp_q.size()); end
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got %b required 0", evt_valid); end
    $display("test_overflow done");
  endtask

  task automatic test_reset_midframe();
    int base;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    #3 reset = 1'b1;
    #27 reset = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_last_v = 1'b0;
    exp_err = 0;
    ps2_data = 1'b1;
    wait_cyc(60);
    assertions += 2;
    if (overflow !== 1'b0) begin failures++; $display("FAIL midreset_overflow got %b required 0", overflow); end
    if (err_count !== 8'd0) begin failures++; $display("FAIL midreset_err got %0d required 0", err_count); end
    base = ev_seen;
    send_key(8'h29, 1'b0);
    assertions++;
    if (ev_seen - base !== 1) begin failures++; $display("FAIL midreset_count got %0d required 1", ev_seen - base); end
    $display("test_reset_midframe done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] keys [8];
    bit done_flag;
    keys = '{8'h1C, 8'hE0, 8'h75, 8'hF0, 8'h33, 8'h6B, 8'h1C, 8'h4D};
    done_flag = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_key(keys[$urandom_range(0, 7)], 1'b0);
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(posedge clock);
          #1 evt_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    evt_ready = 1'b1;
    wait_cyc(40);
    assertions += 2;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_left got %0d required 0", exp_q.size()); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got %b required 0", overflow); end
    $display("test_back_to_back done");
  endtask

  task automatic test_repeat_keys();
    logic [7:0] seq [6];
    int base;
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    apply_reset();
    base = ev_seen;
    for (int i = 0; i < 6; i++) send_key(seq[i], 1'b0);
    assertions += 2;
`ifdef PS2_REPEAT_FILTER_EN
    if (ev_seen - base !== 3) begin failures++; $display("FAIL repeat_count got %0d required 3", ev_seen - base); end
`else
    if (ev_seen - base !== 5) begin failures++; $display("FAIL repeat_count got %0d required 5", ev_seen - base); end
`endif
    if (exp_q.size() != 0) begin failures++; $display("FAIL repeat_left got %0d required 0", exp_q.size()); end
    $display("test_repeat_keys done");
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_ext_break();
    test_errors();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
    test_repeat_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
